// File: rtl/vga_pkg.sv
// Shared constants and types for the VGA memory arbiter slice.
// Latency: n/a (declarations only).
// Backpressure: n/a.
package vga_pkg;

    localparam int AW = 15;
    localparam int DW = 16;

    // Phases of the 4-clock pixel cycle as produced by the timing generator.
    localparam logic [1:0] PS_CHAR  = 2'd0;
    localparam logic [1:0] PS_GLYPH = 2'd1;
    localparam logic [1:0] PS_PIX   = 2'd2;
    localparam logic [1:0] PS_FREE  = 2'd3;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        ACCESS = 2'd1,
        ACK    = 2'd2
    } cpu_state_e;

endpackage

// File: rtl/vga_fill_engine.sv
// Screen-clear engine: writes fill_value to fill_len consecutive words from fill_base.
// Latency: one word per fill_grant; fill_done pulses the cycle after the final write.
// Backpressure: advances only on fill_grant; fill_start while busy is ignored.
//
// Ports: fill_start/base/len/value load a job while idle; fill_grant is the advance
// strobe from the arbiter; fill_addr/fill_wdata present the pending word;
// fill_busy is high while words remain, fill_done is a one-cycle completion pulse.
module vga_fill_engine
    import vga_pkg::*;
#(
    parameter int AW = vga_pkg::AW,
    parameter int DW = vga_pkg::DW
) (
    input  logic          clk,
    input  logic          reset,
    input  logic          fill_start,
    input  logic [AW-1:0] fill_base,
    input  logic [AW-1:0] fill_len,
    input  logic [DW-1:0] fill_value,
    input  logic          fill_grant,
    output logic          fill_busy,
    output logic          fill_done,
    output logic [AW-1:0] fill_addr,
    output logic [DW-1:0] fill_wdata
);

    logic [AW-1:0] addr_q,   addr_d;
    logic [AW-1:0] remain_q, remain_d;
    logic [DW-1:0] value_q,  value_d;
    logic          busy_q,   busy_d;
    logic          done_q,   done_d;

    always_comb begin
        addr_d   = addr_q;
        remain_d = remain_q;
        value_d  = value_q;
        busy_d   = busy_q;
        done_d   = 1'b0;
        if (!busy_q) begin
            if (fill_start) begin
                addr_d   = fill_base;
                remain_d = fill_len;
                value_d  = fill_value;
                // A zero-length job never goes busy; it just reports completion.
                if (fill_len == '0) begin
                    done_d = 1'b1;
                end else begin
                    busy_d = 1'b1;
                end
            end
        end else if (fill_grant) begin
            // Address wraps naturally at 2^AW.
            addr_d   = addr_q + 1'b1;
            remain_d = remain_q - 1'b1;
            if (remain_q == AW'(1)) begin
                busy_d = 1'b0;
                done_d = 1'b1;
            end
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            addr_q   <= '0;
            remain_q <= '0;
            value_q  <= '0;
            busy_q   <= 1'b0;
            done_q   <= 1'b0;
        end else begin
            addr_q   <= addr_d;
            remain_q <= remain_d;
            value_q  <= value_d;
            busy_q   <= busy_d;
            done_q   <= done_d;
        end
    end

    assign fill_busy  = busy_q;
    assign fill_done  = done_q;
    assign fill_addr  = addr_q;
    assign fill_wdata = value_q;

endmodule

// File: rtl/vga_mem_arbiter.sv
// Shares the single-port VGA memory between display fetch, CPU port and fill engine.
// Latency: display never stalls; CPU ack 2 cycles after grant; fill 1 word per granted slot.
// Backpressure: CPU holds cpu_req until cpu_ack; fill waits for free slots, CPU wins ties.
//
// Ports: pixel_state/active/disp_addr come from the timing pipeline, disp_rdata
// returns memory data to it; cpu_* is a req/ack load-store port; fill_* controls
// the clear engine; mem_* drive the synchronous-read memory macro.
module vga_mem_arbiter
    import vga_pkg::*;
#(
    parameter int AW = vga_pkg::AW,
    parameter int DW = vga_pkg::DW
) (
    input  logic          clk,
    input  logic          reset,
    input  logic [1:0]    pixel_state,
    input  logic          active,
    input  logic [AW-1:0] disp_addr,
    output logic [DW-1:0] disp_rdata,
    input  logic          cpu_req,
    input  logic          cpu_we,
    input  logic [AW-1:0] cpu_addr,
    input  logic [DW-1:0] cpu_wdata,
    output logic          cpu_ack,
    output logic [DW-1:0] cpu_rdata,
    input  logic          fill_start,
    input  logic [AW-1:0] fill_base,
    input  logic [AW-1:0] fill_len,
    input  logic [DW-1:0] fill_value,
    output logic          fill_busy,
    output logic          fill_done,
    output logic [AW-1:0] mem_addr,
    output logic          mem_we,
    output logic [DW-1:0] mem_wdata,
    input  logic [DW-1:0] mem_rdata
);

    cpu_state_e    cpu_state_q;
    logic          cpu_we_q;
    logic          cpu_ack_q;
    logic [DW-1:0] cpu_rdata_q;

    logic          slot_free;
    logic          cpu_grant;
    logic          fill_grant;
    logic [AW-1:0] fill_addr;
    logic [DW-1:0] fill_wdata;

    vga_fill_engine #(.AW(AW), .DW(DW)) u_fill (
        .clk        (clk),
        .reset      (reset),
        .fill_start (fill_start),
        .fill_base  (fill_base),
        .fill_len   (fill_len),
        .fill_value (fill_value),
        .fill_grant (fill_grant),
        .fill_busy  (fill_busy),
        .fill_done  (fill_done),
        .fill_addr  (fill_addr),
        .fill_wdata (fill_wdata)
    );

    // Display owns the char/glyph phases of visible pixel cycles; everything
    // else is shared. Grants are masked while reset is held so a pending
    // cpu_req cannot steer the memory port away from the display.
    always_comb begin
        slot_free  = !active || (pixel_state >= PS_PIX);
        cpu_grant  = !reset && slot_free && cpu_req && (cpu_state_q == IDLE);
        fill_grant = !reset && slot_free && !cpu_grant && fill_busy;

        mem_addr  = disp_addr;
        mem_we    = 1'b0;
        mem_wdata = '0;
        if (cpu_grant) begin
            mem_addr  = cpu_addr;
            mem_we    = cpu_we;
            mem_wdata = cpu_wdata;
        end else if (fill_grant) begin
            mem_addr  = fill_addr;
            mem_we    = 1'b1;
            mem_wdata = fill_wdata;
        end
    end

    // The memory is addressed in the grant cycle, so only the direction needs
    // to be remembered; read data arrives during ACCESS and is captured at its
    // end, before any later fill write can reuse the port's read path.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            cpu_state_q <= IDLE;
            cpu_we_q    <= 1'b0;
            cpu_ack_q   <= 1'b0;
            cpu_rdata_q <= '0;
        end else begin
            case (cpu_state_q)
                IDLE: begin
                    cpu_ack_q <= 1'b0;
                    if (cpu_grant) begin
                        cpu_state_q <= ACCESS;
                        cpu_we_q    <= cpu_we;
                    end
                end
                ACCESS: begin
                    cpu_state_q <= ACK;
                    cpu_ack_q   <= 1'b1;
                    if (!cpu_we_q) begin
                        cpu_rdata_q <= mem_rdata;
                    end
                end
                ACK: begin
                    cpu_state_q <= IDLE;
                    cpu_ack_q   <= 1'b0;
                end
                default: begin
                    cpu_state_q <= IDLE;
                    cpu_ack_q   <= 1'b0;
                end
            endcase
        end
    end

    assign cpu_ack    = cpu_ack_q;
    assign cpu_rdata  = cpu_rdata_q;
    assign disp_rdata = mem_rdata;

endmodule

// File: tb/tb_vga_mem_arbiter.sv
// Scoreboard bench for vga_mem_arbiter: a driver pushes expected CPU acks and
// fill writes into queues, a negedge monitor pops and compares them, and a
// plain array stands in for the memory macro.
module tb_vga_mem_arbiter;

    localparam int AW = 15;
    localparam int DW = 16;

    logic          clk = 1'b0;
    logic          reset;
    logic [1:0]    pixel_state;
    logic          active;
    logic [AW-1:0] disp_addr;
    logic [DW-1:0] disp_rdata;
    logic          cpu_req, cpu_we, cpu_ack;
    logic [AW-1:0] cpu_addr;
    logic [DW-1:0] cpu_wdata, cpu_rdata;
    logic          fill_start, fill_busy, fill_done;
    logic [AW-1:0] fill_base, fill_len;
    logic [DW-1:0] fill_value;
    logic [AW-1:0] mem_addr;
    logic          mem_we;
    logic [DW-1:0] mem_wdata, mem_rdata;

    vga_mem_arbiter #(.AW(AW), .DW(DW)) dut (
        .clk(clk), .reset(reset), .pixel_state(pixel_state), .active(active),
        .disp_addr(disp_addr), .disp_rdata(disp_rdata),
        .cpu_req(cpu_req), .cpu_we(cpu_we), .cpu_addr(cpu_addr), .cpu_wdata(cpu_wdata),
        .cpu_ack(cpu_ack), .cpu_rdata(cpu_rdata),
        .fill_start(fill_start), .fill_base(fill_base), .fill_len(fill_len),
        .fill_value(fill_value), .fill_busy(fill_busy), .fill_done(fill_done),
        .mem_addr(mem_addr), .mem_we(mem_we), .mem_wdata(mem_wdata), .mem_rdata(mem_rdata)
    );

    always #5 clk = ~clk;

    // Memory macro: synchronous read, one cycle latency.
    logic [DW-1:0] mem [0:32767];
    always @(posedge clk) begin
        if (mem_we) mem[mem_addr] <= mem_wdata;
        mem_rdata <= mem[mem_addr];
    end

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    // Timing generator: phase advances every clock, display address is random.
    initial begin
        pixel_state = 2'd0;
        disp_addr   = '0;
        forever begin
            @(posedge clk);
            #1;
            pixel_state = pixel_state + 2'd1;
            disp_addr   = AW'($urandom);
        end
    end

    // Reference model state.
    typedef struct { bit we; logic [DW-1:0] rdata; int ack_cyc; } cpu_exp_t;
    typedef struct { logic [AW-1:0] addr; logic [DW-1:0] val; } fill_exp_t;
    cpu_exp_t      cpuq[$];
    fill_exp_t     fillq[$];
    logic [DW-1:0] ref_mem [0:32767];
    bit            written [0:32767];
    logic [DW-1:0] last_rd = '0;
    int            fill_busy_from = 32'h7fff_ffff;
    int            exp_done_cyc   = -1;
    int            vectors = 0;
    int            errors  = 0;

    task automatic step();
        @(posedge clk);
        #2;
    endtask

    task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
        vectors++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h, expected %h (cycle %0d)", nm, act, exp, cyc);
        end
    endtask

    // Memory is free for CPU/fill in blanking and in the last two pixel phases.
    // Valid for future cycles only while 'active' is held constant.
    function automatic bit sf_at(input int c);
        logic [1:0] ps;
        ps = pixel_state + 2'(c - cyc);
        return !active || (ps >= 2'd2);
    endfunction

    // Cycle in which fill_done should pulse when n words need n free slots after start.
    function automatic int pred_done(input int start, input int n);
        int c, cnt;
        c = start; cnt = 0;
        if (n == 0) return start + 1;
        while (cnt < n) begin
            c++;
            if (sf_at(c)) cnt++;
        end
        return c + 1;
    endfunction

    task automatic cpu_op(input bit we, input logic [AW-1:0] addr, input logic [DW-1:0] data);
        cpu_exp_t e;
        int c, n;
        cpu_req = 1'b1; cpu_we = we; cpu_addr = addr; cpu_wdata = data;
        c = cyc;
        while (!sf_at(c)) c++;
        e.we = we;
        e.ack_cyc = c + 2;
        if (we) begin
            ref_mem[addr] = data; written[addr] = 1'b1; e.rdata = last_rd;
        end else begin
            e.rdata = ref_mem[addr]; last_rd = ref_mem[addr];
        end
        cpuq.push_back(e);
        n = 0;
        while (cpu_ack !== 1'b1 && n < 40) begin step(); n++; end
        if (n >= 40) begin
            vectors++; errors++;
            $display("FAIL cpu_ack_timeout: got no ack, expected ack by cycle %0d", e.ack_cyc);
            cpuq.delete();
        end
        step();
    endtask

    task automatic fill_op(input logic [AW-1:0] base, input int len,
                           input logic [DW-1:0] val, output int pred);
        fill_exp_t f;
        pred = -1;
        fill_start = 1'b1; fill_base = base; fill_len = AW'(len); fill_value = val;
        if (fillq.size() == 0) begin
            for (int i = 0; i < len; i++) begin
                f.addr = AW'(int'(base) + i);
                f.val  = val;
                fillq.push_back(f);
            end
            fill_busy_from = cyc + 1;
            if (len == 0) exp_done_cyc = cyc + 1;
            pred = pred_done(cyc, len);
        end
        step();
        fill_start = 1'b0;
    endtask

    task automatic wait_fill(input int pred);
        int n;
        n = 0;
        while (fill_done !== 1'b1 && n < 400) begin step(); n++; end
        if (n >= 400) begin
            vectors++; errors++;
            $display("FAIL fill_done_timeout: got no fill_done, expected one");
        end else if (pred >= 0) begin
            check("fill_done_cycle", cyc, pred);
        end
        step();
    endtask

    task automatic check_reset_values();
        check("rst_cpu_ack",   cpu_ack,   0);
        check("rst_cpu_rdata", cpu_rdata, 0);
        check("rst_fill_busy", fill_busy, 0);
        check("rst_fill_done", fill_done, 0);
        check("rst_mem_we",    mem_we,    0);
        check("rst_mem_wdata", mem_wdata, 0);
        check("rst_mem_addr",  mem_addr,  disp_addr);
    endtask

    // Monitor: compares everything the DUT presents against the queues.
    initial begin
        cpu_exp_t e;
        forever begin
            @(negedge clk);
            if (!reset) begin
                if (active && pixel_state < 2'd2) begin
                    check("disp_slot_addr", mem_addr, disp_addr);
                    check("disp_slot_we", mem_we, 0);
                end
                check("disp_rdata", disp_rdata, mem_rdata);
                check("fill_busy", fill_busy, (fillq.size() > 0 && cyc >= fill_busy_from));
                if (mem_we) begin
                    if (fillq.size() > 0 && mem_addr == fillq[0].addr && mem_wdata == fillq[0].val) begin
                        vectors++;
                        ref_mem[mem_addr] = mem_wdata;
                        written[mem_addr] = 1'b1;
                        void'(fillq.pop_front());
                        if (fillq.size() == 0) exp_done_cyc = cyc + 1;
                    end else if (!(cpu_req && cpu_we && mem_addr == cpu_addr && mem_wdata == cpu_wdata)) begin
                        vectors++; errors++;
                        $display("FAIL stray_write: got write %h<=%h, expected fill %h<=%h or cpu %h<=%h",
                                 mem_addr, mem_wdata,
                                 fillq.size() > 0 ? fillq[0].addr : '0,
                                 fillq.size() > 0 ? fillq[0].val : '0, cpu_addr, cpu_wdata);
                    end
                end
                if (fill_done || cyc == exp_done_cyc)
                    check("fill_done", fill_done, (cyc == exp_done_cyc));
                if (cpu_ack) begin
                    if (cpuq.size() == 0) begin
                        vectors++; errors++;
                        $display("FAIL cpu_ack_unexpected: got ack, expected none (cycle %0d)", cyc);
                    end else begin
                        e = cpuq.pop_front();
                        check("cpu_ack_cycle", cyc, e.ack_cyc);
                        check("cpu_rdata", cpu_rdata, e.rdata);
                    end
                end
            end
        end
    end

    initial begin
        #600000;
        $display("FAIL watchdog: got no finish, expected end of test");
        $fatal(1);
    end

    initial begin
        int pr, pr2, n, s;
        logic [AW-1:0] a;
        bit we;
        reset = 1'b1; active = 1'b0;
        cpu_req = 0; cpu_we = 0; cpu_addr = '0; cpu_wdata = '0;
        fill_start = 0; fill_base = '0; fill_len = '0; fill_value = '0;
        repeat (3) step();
        check_reset_values();
        reset = 1'b0;
        step();

        // Preload then read back during the visible region, request in phase 0.
        cpu_op(1'b1, 15'h0100, 16'hBEEF);
        cpu_req = 1'b0; step();
        active = 1'b1;
        n = 0;
        while (pixel_state != 2'd0 && n < 8) begin step(); n++; end
        cpu_op(1'b0, 15'h0100, 16'h0000);
        cpu_req = 1'b0; step();

        // Back-to-back writes under continuous display fetch, then readback.
        for (int i = 0; i < 16; i++) cpu_op(1'b1, AW'(i), 16'hA500 + 16'(i));
        cpu_op(1'b0, 15'h0003, 16'h0000);
        cpu_op(1'b0, 15'h000F, 16'h0000);
        cpu_req = 1'b0; step();

        // Blanking fill wrapping past the top of memory.
        active = 1'b0;
        fill_op(15'h7FFE, 4, 16'h0020, pr);
        wait_fill(pr);

        // Zero-length fill, then a start during busy that must be ignored.
        fill_op(15'h3000, 0, 16'hAAAA, pr);
        wait_fill(pr);
        active = 1'b1;
        fill_op(15'h3100, 8, 16'h1111, pr);
        step();
        fill_op(15'h3200, 8, 16'h2222, pr2);
        wait_fill(pr);

        // CPU write steals one slot from a running fill.
        active = 1'b1;
        s = cyc;
        fill_op(15'h2000, 40, 16'h00F0, pr);
        n = 0;
        while (fillq.size() > 30 && n < 200) begin step(); n++; end
        cpu_op(1'b1, 15'h2002, 16'h1234);
        cpu_req = 1'b0;
        wait_fill(pred_done(s, 41));
        step();
        for (int i = 0; i < 40; i++) begin
            a = AW'(16'h2000 + i);
            check("fill_cpu_mem", mem[a], (a == 15'h2002) ? 16'h1234 : 16'h00F0);
        end

        // Reset during CPU ACCESS and mid-fill.
        active = 1'b0;
        fill_op(15'h6000, 100, 16'h7777, pr);
        repeat (4) step();
        cpu_req = 1'b1; cpu_we = 1'b0; cpu_addr = 15'h0100;
        step();
        #1 reset = 1'b1;
        cpuq.delete(); fillq.delete();
        fill_busy_from = 32'h7fff_ffff; exp_done_cyc = -1; last_rd = '0;
        #1 check_reset_values();
        repeat (2) step();
        check_reset_values();
        cpu_req = 1'b0; reset = 1'b0;
        repeat (10) step();
        cpu_op(1'b0, 15'h0100, 16'h0000);
        cpu_req = 1'b0; step();

        // Randomized mix of CPU traffic, fills and region changes.
        for (int it = 0; it < 150; it++) begin
            active = ($urandom % 3 != 0);
            case ($urandom % 8)
                0: begin
                    cpu_req = 1'b0;
                    fill_op(AW'(16'h5000 + $urandom_range(255)), $urandom_range(20),
                            DW'($urandom), pr);
                end
                1: begin
                    cpu_req = 1'b0;
                    repeat ($urandom_range(1, 3)) step();
                end
                default: begin
                    we = $urandom % 2;
                    a  = ($urandom % 2) ? AW'(16'h4000 + $urandom_range(63)) : AW'($urandom_range(15));
                    if (!we && !written[a]) we = 1'b1;
                    cpu_op(we, a, DW'($urandom));
                    if ($urandom % 2) begin cpu_req = 1'b0; step(); end
                end
            endcase
        end
        cpu_req = 1'b0;
        n = 0;
        while ((fillq.size() > 0 || cyc <= exp_done_cyc) && n < 2000) begin step(); n++; end
        repeat (3) step();

        $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
        $finish;
    end

endmodule
